reg_dump_unit: RTL and testbench
================================

# reg_dump_unit

Register-file readout engine for the processor testbench. On a start request it walks all 8 registers of the register file through the file's two combinational read ports, two registers per access, and streams each value out with its register number over a valid/ready handshake. It is the reader-side counterpart of the register file's write port; it drives the file's `OUT1ADDRESS`/`OUT2ADDRESS` and consumes `OUT1`/`OUT2`.

## Interface
- `NUM_REGS`, default 8: registers dumped, from 0 to `NUM_REGS-1`; must be even, 2..8.
- `SETTLE_CYCLES`, default 1: clock edges to wait after the read addresses change before sampling the read data; must be ≥1. This covers the register file's 2-time-unit read delay.
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `START` in 1: request a dump; sampled only in IDLE.
- `ABORT` in 1: synchronous cancel; overrides everything except reset.
- `RF_OUT1ADDRESS` out 3: to the register file's `OUT1ADDRESS`; always carries the even register of the current pair.
- `RF_OUT2ADDRESS` out 3: to the register file's `OUT2ADDRESS`; always carries the odd register of the current pair.
- `RF_OUT1` in 8: from the register file's `OUT1`.
- `RF_OUT2` in 8: from the register file's `OUT2`.
- `DVALID` out 1: `DOUT`/`DADDR` hold a valid beat.
- `DREADY` in 1: the consumer accepts the beat.
- `DOUT` out 8: register value.
- `DADDR` out 3: register number of `DOUT`.
- `BUSY` out 1: high from the START edge until the DONE cycle ends.
- `DONE` out 1: one-cycle pulse after the last beat is accepted.

## Operation
- All outputs are registered.
- Reset values: `RF_OUT1ADDRESS`=0, `RF_OUT2ADDRESS`=0, `DVALID`=0, `DOUT`=0, `DADDR`=0, `BUSY`=0, `DONE`=0, state IDLE, pair index 0.
- The states are IDLE, SETTLE, SEND_A, SEND_B and FIN.
- IDLE:
  - `START`=1 at an edge sets `RF_OUT1ADDRESS`=0 and `RF_OUT2ADDRESS`=1.
  - It loads the settle counter with `SETTLE_CYCLES`, sets `BUSY`=1 and moves to SETTLE.
- SETTLE:
  - The counter decrements at each edge.
  - At the edge where the counter equals 1, the block latches `RF_OUT1` into buffer A and `RF_OUT2` into buffer B.
  - On that same edge it drives `DOUT`=A, `DADDR`=even index, `DVALID`=1 and moves to SEND_A.
- SEND_A: at an edge with `DREADY`=1, it drives `DOUT`=B and `DADDR`=odd index, keeps `DVALID`=1 and moves to SEND_B.
- SEND_B, at an edge with `DREADY`=1:
  - If more pairs remain: `DVALID`=0, addresses advance by 2, the counter reloads, and the state returns to SETTLE.
  - If this was the last pair: `DVALID`=0, `DONE`=1, and the state moves to FIN.
- FIN: after one cycle, `DONE`=0, `BUSY`=0, state IDLE.
- Handshake rules:
  - A beat transfers at any edge where `DVALID` and `DREADY` are both 1.
  - While `DVALID`=1 and `DREADY`=0, `DOUT` and `DADDR` are held stable.
  - `DVALID` never depends combinationally on `DREADY`.
- `START` while `BUSY`=1 is ignored; no queueing.
- `ABORT`=1 at any edge:
  - State goes to IDLE with `DVALID`=0 and `BUSY`=0.
  - `DONE` is not pulsed and addresses return to 0.
  - A beat offered at the same edge is not counted as transferred.
- `ABORT` and `START` high together in IDLE: `ABORT` wins and the block stays idle.
- Asynchronous reset mid-dump: all outputs take their reset values immediately and the dump is lost.
- Values are captured once per pair, so a register-file write during a dump is visible only if it occurs before that pair's capture edge.

## Timing
- Call the START edge E0; it assumes `SETTLE_CYCLES`=1 and `DREADY` held high.
  - First capture at E1; register 0 transfers at E2 and register 1 at E3.
  - Pair k transfers its odd register at E(3+3k).
  - With `NUM_REGS`=8, the last beat is at E12, `DONE` is high between E12 and E13, and `BUSY` falls at E13.
- General per-pair cost: `SETTLE_CYCLES` + 2 edges, plus any cycles with `DREADY`=0.
- Address outputs change only at the START edge or at the edge accepting an odd beat.
- They are stable for at least `SETTLE_CYCLES` full clock periods before capture.

## Test plan
- Preload registers 0..7 with 0x10..0x17, pulse `START`, hold `DREADY`=1: eight beats with (`DADDR`,`DOUT`) = (0,0x10)…(7,0x17), the last at E12; `DONE` is a one-cycle pulse at E12–E13.
- Same preload, toggle `DREADY` 1/0 every cycle: the same eight beats in order, and `DOUT`/`DADDR` never change while `DVALID`=1 and `DREADY`=0.
- Set `SETTLE_CYCLES`=3, write register 5 to 0xAA two cycles after `START`: the beat for `DADDR`=5 carries 0xAA, and the addresses are stable for 3 cycles before each capture.
- Assert `ABORT` during the SEND_B of register 3 with `DREADY`=1: `DVALID` and `BUSY` go to 0 next edge, `DONE` never pulses, and a new `START` restarts at register 0.
- Pull `RESET` low asynchronously mid-SETTLE: all outputs go to 0 without waiting for a clock edge; after release, `START` produces a full correct dump.
- Pulse `START` while `BUSY`=1, and separately raise `START` and `ABORT` together in IDLE: neither case changes the beat sequence or leaves IDLE.

Source files
------------

// File: rtl/reg_dump_unit.sv
// reg_dump_unit
//   Streams the contents of a register file out over a valid/ready channel.
//   On START the unit walks the file two registers at a time: it drives the
//   even register number on RF_OUT1ADDRESS and the odd one on RF_OUT2ADDRESS,
//   waits SETTLE_CYCLES edges for the file's read data to settle, captures
//   both read ports, then offers the even value followed by the odd value.
//
// Ports
//   CLK, RESET          clock (rising edge), async active-low reset
//   START, ABORT        begin a dump (IDLE only) / synchronous cancel
//   RF_OUT1ADDRESS/2    read addresses to the register file (even/odd)
//   RF_OUT1/RF_OUT2     read data from the register file
//   DVALID/DREADY       output beat handshake
//   DOUT, DADDR         beat payload: register value and register number
//   BUSY, DONE          dump in progress / one-cycle completion pulse
module reg_dump_unit #(
  parameter int NUM_REGS      = 8,  // even, 2..8
  parameter int SETTLE_CYCLES = 1   // >= 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       ABORT,
  output logic [2:0] RF_OUT1ADDRESS,
  output logic [2:0] RF_OUT2ADDRESS,
  input  logic [7:0] RF_OUT1,
  input  logic [7:0] RF_OUT2,
  output logic       DVALID,
  input  logic       DREADY,
  output logic [7:0] DOUT,
  output logic [2:0] DADDR,
  output logic       BUSY,
  output logic       DONE
);

  localparam int             CW        = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  SETTLE_LD = CW'(SETTLE_CYCLES);
  localparam logic [1:0]     LAST_PAIR = 2'(NUM_REGS / 2 - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, SEND_A, SEND_B, FIN} state_t;

  state_t        state;
  logic [1:0]    pair;
  logic [CW-1:0] cnt;
  logic [7:0]    buf_b;  // odd register of the pair, held while the even beat drains

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= IDLE;
      pair           <= '0;
      cnt            <= '0;
      buf_b          <= '0;
      RF_OUT1ADDRESS <= '0;
      RF_OUT2ADDRESS <= '0;
      DVALID         <= 1'b0;
      DOUT           <= '0;
      DADDR          <= '0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
    end else if (ABORT) begin
      // Any beat offered at this edge is dropped, not transferred.
      state          <= IDLE;
      pair           <= '0;
      cnt            <= '0;
      RF_OUT1ADDRESS <= '0;
      RF_OUT2ADDRESS <= '0;
      DVALID         <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            RF_OUT1ADDRESS <= 3'd0;
            RF_OUT2ADDRESS <= 3'd1;
            pair           <= '0;
            cnt            <= SETTLE_LD;
            BUSY           <= 1'b1;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Capture both ports on the same edge; DOUT doubles as buffer A.
            buf_b  <= RF_OUT2;
            DOUT   <= RF_OUT1;
            DADDR  <= RF_OUT1ADDRESS;
            DVALID <= 1'b1;
            state  <= SEND_A;
          end
        end
        SEND_A: begin
          if (DREADY) begin
            DOUT  <= buf_b;
            DADDR <= RF_OUT2ADDRESS;
            state <= SEND_B;
          end
        end
        SEND_B: begin
          if (DREADY) begin
            DVALID <= 1'b0;
            if (pair == LAST_PAIR) begin
              DONE  <= 1'b1;
              state <= FIN;
            end else begin
              // Addresses move only here, so they are stable through the
              // whole settle window of the next pair.
              pair           <= pair + 2'd1;
              RF_OUT1ADDRESS <= RF_OUT1ADDRESS + 3'd2;
              RF_OUT2ADDRESS <= RF_OUT2ADDRESS + 3'd2;
              cnt            <= SETTLE_LD;
              state          <= SETTLE;
            end
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
module tb_reg_dump_unit;
  localparam int NR = 8;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, dready;
  logic [2:0] a1[2], a2[2], daddr[2];
  logic [7:0] o1[2], o2[2], dout[2];
  logic       dvalid[2], busy[2], done[2];
  logic [7:0] rf[NR];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Register file read ports (combinational), one pair per DUT.
  assign o1[0] = rf[a1[0]];
  assign o2[0] = rf[a2[0]];
  assign o1[1] = rf[a1[1]];
  assign o2[1] = rf[a2[1]];

  reg_dump_unit u_d1 (
    .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort),
    .RF_OUT1ADDRESS(a1[0]), .RF_OUT2ADDRESS(a2[0]),
    .RF_OUT1(o1[0]), .RF_OUT2(o2[0]),
    .DVALID(dvalid[0]), .DREADY(dready), .DOUT(dout[0]), .DADDR(daddr[0]),
    .BUSY(busy[0]), .DONE(done[0]));

  reg_dump_unit #(.SETTLE_CYCLES(3)) u_d3 (
    .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort),
    .RF_OUT1ADDRESS(a1[1]), .RF_OUT2ADDRESS(a2[1]),
    .RF_OUT1(o1[1]), .RF_OUT2(o2[1]),
    .DVALID(dvalid[1]), .DREADY(dready), .DOUT(dout[1]), .DADDR(daddr[1]),
    .BUSY(busy[1]), .DONE(done[1]));

  // Observation queues (filled at negedge, i.e. away from the active edge).
  // Beat word: edge<<16 | addr<<8 | data. Address-change word: edge<<8 | a1<<4 | a2.
  int got0[$], got1[$], dn0[$], dn1[$], ch0[$], ch1[$];
  int viol[2];
  int bfall[2];
  logic        pstall[2];
  logic [10:0] pbeat[2];
  logic [5:0]  pa[2];
  logic        pbusy[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int b, c;
      b = ((cyc + 1) << 16) | (int'(daddr[i]) << 8) | int'(dout[i]);
      c = (cyc << 8) | (int'(a1[i]) << 4) | int'(a2[i]);
      if (rst_n) begin
        if (pstall[i] && (!dvalid[i] || {daddr[i], dout[i]} != pbeat[i])) viol[i]++;
        if (dvalid[i] && dready && !abort) begin
          if (i == 0) got0.push_back(b); else got1.push_back(b);
        end
        if (done[i]) begin
          if (i == 0) dn0.push_back(cyc); else dn1.push_back(cyc);
        end
        if ({a1[i], a2[i]} != pa[i]) begin
          if (i == 0) ch0.push_back(c); else ch1.push_back(c);
        end
        if (pbusy[i] && !busy[i]) bfall[i] = cyc;
      end
      pa[i]     = {a1[i], a2[i]};
      pbusy[i]  = busy[i];
      pstall[i] = rst_n && dvalid[i] && !dready && !abort;
      pbeat[i]  = {daddr[i], dout[i]};
    end
  end

  // Edge at which register r is accepted, dump started at e0, DREADY held high.
  function automatic int ideal(int e0, int s, int r);
    return e0 + (r / 2) * (s + 2) + s + 1 + (r % 2);
  endfunction

  task automatic clear_obs();
    got0.delete(); got1.delete(); dn0.delete(); dn1.delete();
    ch0.delete(); ch1.delete();
    viol[0] = 0; viol[1] = 0; bfall[0] = -1; bfall[1] = -1;
  endtask

  task automatic preload_seq();
    for (int r = 0; r < NR; r++) rf[r] = 8'(8'h10 + r);
  endtask

  task automatic preload_rand();
    for (int r = 0; r < NR; r++) rf[r] = 8'($urandom);
  endtask

  // Returns the START edge number.
  task automatic start_dump(output int e0);
    clear_obs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy[0] || busy[1]) && n < 400) begin
      @(posedge clk); #1 n++;
    end
    checks++;
    if (busy[0] || busy[1]) begin
      errors++;
      $display("FAIL %s timeout: busy=%0b%0b required 00", nm, busy[1], busy[0]);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; dready = 1;
    preload_seq();
    #3;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({dvalid[i], busy[i], done[i], dout[i], daddr[i], a1[i], a2[i]} !== 22'd0) begin
        errors++;
        $display("FAIL reset[%0d]: v=%0b b=%0b d=%0b dout=%h daddr=%0d a=%0d/%0d required all 0",
                 i, dvalid[i], busy[i], done[i], dout[i], daddr[i], a1[i], a2[i]);
      end
    end
    #4 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_full_dump();
    int e0, s, q[$], exp;
    preload_seq();
    dready = 1;
    start_dump(e0);
    wait_idle("full_dump");
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? 1 : 3;
      if (i == 0) q = got0; else q = got1;
      checks++;
      if (q.size() != NR) begin
        errors++;
        $display("FAIL full_dump[%0d] beat count: got %0d required %0d", i, q.size(), NR);
      end else begin
        for (int r = 0; r < NR; r++) begin
          exp = (ideal(e0, s, r) << 16) | (r << 8) | (8'h10 + r);
          checks++;
          if (q[r] != exp) begin
            errors++;
            $display("FAIL full_dump[%0d] beat %0d: got edge %0d addr %0d data %h required edge %0d addr %0d data %h",
                     i, r, (q[r] >> 16) - e0, (q[r] >> 8) & 7, q[r] & 255, (exp >> 16) - e0, r, 8'h10 + r);
          end
        end
      end
      if (i == 0) q = dn0; else q = dn1;
      checks++;
      if (q.size() != 1 || q[0] != e0 + (NR / 2) * (s + 2)) begin
        errors++;
        $display("FAIL full_dump[%0d] done: pulses %0d first at E%0d required 1 at E%0d",
                 i, q.size(), (q.size() > 0) ? q[0] - e0 : -1, (NR / 2) * (s + 2));
      end
      checks++;
      if (bfall[i] != e0 + (NR / 2) * (s + 2) + 1) begin
        errors++;
        $display("FAIL full_dump[%0d] busy fall: E%0d required E%0d",
                 i, bfall[i] - e0, (NR / 2) * (s + 2) + 1);
      end
    end
  endtask

  task automatic test_stall();
    int e0, q[$];
    logic [7:0] snap[NR];
    preload_rand();
    snap = rf;
    dready = 1;
    clear_obs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; e0 = cyc;
    for (int n = 0; n < 200 && (busy[0] || busy[1]); n++) begin
      dready = ~dready;
      @(posedge clk); #1;
    end
    dready = 1;
    wait_idle("stall");
    for (int i = 0; i < 2; i++) begin
      if (i == 0) q = got0; else q = got1;
      checks++;
      if (q.size() != NR) begin
        errors++;
        $display("FAIL stall[%0d] beat count: got %0d required %0d", i, q.size(), NR);
      end else begin
        for (int r = 0; r < NR; r++) begin
          checks++;
          if ((q[r] & 16'hFFFF) != ((r << 8) | int'(snap[r]))) begin
            errors++;
            $display("FAIL stall[%0d] beat %0d: got addr %0d data %h required addr %0d data %h",
                     i, r, (q[r] >> 8) & 7, q[r] & 255, r, snap[r]);
          end
        end
      end
      checks++;
      if (viol[i] != 0) begin
        errors++;
        $display("FAIL stall[%0d] hold: %0d payload changes under backpressure required 0", i, viol[i]);
      end
    end
  endtask

  task automatic test_write_during();
    int e0, s, q[$], exp;
    logic [7:0] r0;
    preload_seq();
    dready = 1;
    start_dump(e0);
    @(posedge clk);              // E1
    @(posedge clk); #1;          // E2: register file write
    rf[0] = 8'h55;
    rf[5] = 8'hAA;
    wait_idle("write_during");
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? 1 : 3;
      // Register 0 is captured at E1 by the 1-cycle unit, at E3 by the 3-cycle unit.
      r0 = (i == 0) ? 8'h10 : 8'h55;
      if (i == 0) q = got0; else q = got1;
      checks++;
      if (q.size() != NR || (q[0] & 255) != int'(r0) || (q[5] & 16'hFFFF) != ((5 << 8) | 8'hAA)) begin
        errors++;
        $display("FAIL write_during[%0d]: n=%0d reg0=%h reg5=%h required n=%0d reg0=%h reg5=aa",
                 i, q.size(), (q.size() > 0) ? q[0] & 255 : -1, (q.size() > 5) ? q[5] & 255 : -1, NR, r0);
      end
      if (i == 0) q = ch0; else q = ch1;
      checks++;
      if (q.size() != NR / 2) begin
        errors++;
        $display("FAIL addr_changes[%0d]: got %0d required %0d", i, q.size(), NR / 2);
      end else begin
        for (int k = 0; k < NR / 2; k++) begin
          exp = ((e0 + k * (s + 2)) << 8) | ((2 * k) << 4) | (2 * k + 1);
          checks++;
          if (q[k] != exp) begin
            errors++;
            $display("FAIL addr_change[%0d] %0d: got E%0d a=%0d/%0d required E%0d a=%0d/%0d",
                     i, k, (q[k] >> 8) - e0, (q[k] >> 4) & 15, q[k] & 15, k * (s + 2), 2 * k, 2 * k + 1);
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    int e0, ae, n, s, q[$], nexp;
    logic [7:0] snap[NR];
    preload_rand();
    snap = rf;
    dready = 1;
    start_dump(e0);
    n = 0;
    while (!(dvalid[0] && daddr[0] == 3'd3) && n < 50) begin
      @(posedge clk); #1 n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL abort wait: register 3 beat never offered");
    end
    abort = 1'b1;
    ae = cyc + 1;
    @(posedge clk); #1 abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({dvalid[i], busy[i], done[i], a1[i], a2[i]} !== 9'd0) begin
        errors++;
        $display("FAIL abort[%0d] state: v=%0b b=%0b d=%0b a=%0d/%0d required all 0",
                 i, dvalid[i], busy[i], done[i], a1[i], a2[i]);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? 1 : 3;
      if (i == 0) q = got0; else q = got1;
      nexp = 0;
      for (int r = 0; r < NR; r++) if (ideal(e0, s, r) < ae) nexp++;
      checks++;
      if (q.size() != nexp) begin
        errors++;
        $display("FAIL abort[%0d] beats: got %0d required %0d", i, q.size(), nexp);
      end else begin
        for (int r = 0; r < nexp; r++) begin
          checks++;
          if ((q[r] & 16'hFFFF) != ((r << 8) | int'(snap[r]))) begin
            errors++;
            $display("FAIL abort[%0d] beat %0d: got %h required %h", i, r, q[r] & 16'hFFFF, (r << 8) | int'(snap[r]));
          end
        end
      end
      checks++;
      if (((i == 0) ? dn0.size() : dn1.size()) != 0 || busy[i]) begin
        errors++;
        $display("FAIL abort[%0d] done/busy: pulses %0d busy %0b required 0 0",
                 i, (i == 0) ? dn0.size() : dn1.size(), busy[i]);
      end
    end
    // Restart must begin again at register 0.
    start_dump(e0);
    wait_idle("abort_restart");
    for (int i = 0; i < 2; i++) begin
      if (i == 0) q = got0; else q = got1;
      checks++;
      if (q.size() != NR) begin
        errors++;
        $display("FAIL abort_restart[%0d] count: got %0d required %0d", i, q.size(), NR);
      end else begin
        for (int r = 0; r < NR; r++) begin
          checks++;
          if ((q[r] & 16'hFFFF) != ((r << 8) | int'(snap[r]))) begin
            errors++;
            $display("FAIL abort_restart[%0d] beat %0d: got %h required %h", i, r, q[r] & 16'hFFFF, (r << 8) | int'(snap[r]));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e0, q[$];
    logic [7:0] snap[NR];
    preload_rand();
    rf[0] = 8'h81;  // guarantees a nonzero DOUT before the reset hits
    snap = rf;
    dready = 1;
    start_dump(e0);
    @(posedge clk);      // E1: 1-cycle unit captured, 3-cycle unit mid-settle
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({dvalid[i], busy[i], done[i], dout[i], daddr[i], a1[i], a2[i]} !== 22'd0) begin
        errors++;
        $display("FAIL reset_mid[%0d]: v=%0b b=%0b d=%0b dout=%h daddr=%0d a=%0d/%0d required all 0",
                 i, dvalid[i], busy[i], done[i], dout[i], daddr[i], a1[i], a2[i]);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    start_dump(e0);
    wait_idle("reset_mid_dump");
    for (int i = 0; i < 2; i++) begin
      if (i == 0) q = got0; else q = got1;
      checks++;
      if (q.size() != NR) begin
        errors++;
        $display("FAIL reset_mid_dump[%0d] count: got %0d required %0d", i, q.size(), NR);
      end else begin
        for (int r = 0; r < NR; r++) begin
          checks++;
          if ((q[r] & 16'hFFFF) != ((r << 8) | int'(snap[r]))) begin
            errors++;
            $display("FAIL reset_mid_dump[%0d] beat %0d: got %h required %h", i, r, q[r] & 16'hFFFF, (r << 8) | int'(snap[r]));
          end
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int e0, s, q[$], exp;
    logic [7:0] snap[NR];
    preload_rand();
    snap = rf;
    dready = 1;
    start_dump(e0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("start_ignored");
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? 1 : 3;
      if (i == 0) q = got0; else q = got1;
      checks++;
      if (q.size() != NR || ((i == 0) ? dn0.size() : dn1.size()) != 1) begin
        errors++;
        $display("FAIL start_ignored[%0d]: beats %0d dones %0d required %0d 1",
                 i, q.size(), (i == 0) ? dn0.size() : dn1.size(), NR);
      end else begin
        for (int r = 0; r < NR; r++) begin
          exp = (ideal(e0, s, r) << 16) | (r << 8) | int'(snap[r]);
          checks++;
          if (q[r] != exp) begin
            errors++;
            $display("FAIL start_ignored[%0d] beat %0d: got %h required %h", i, r, q[r], exp);
          end
        end
      end
    end
    // START and ABORT together in IDLE: stays idle.
    clear_obs();
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy[i] || dvalid[i] || ((i == 0) ? got0.size() : got1.size()) != 0) begin
        errors++;
        $display("FAIL start_abort[%0d]: busy %0b valid %0b beats %0d required 0 0 0",
                 i, busy[i], dvalid[i], (i == 0) ? got0.size() : got1.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_stall();
    test_write_during();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
